// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_scoreboard_pkg                                      |
// | Desc   : Shared widths and helpers for the scoreboarded register     |
// |          file and its per-register pending counters.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package regfile_scoreboard_pkg;

  // Default datapath geometry of the instruction pipeline
  localparam int DEF_LEN_REG   = 16;
  localparam int DEF_LEN_REGNO = 3;
  localparam int DEF_LEN_PEND  = 2;

  // Largest count a pending counter of the given width can hold
  function automatic int pend_max(input int len);
    return (1 << len) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_pend_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_pend_ctr                                            |
// | Desc   : Saturating up/down count of writes in flight to one         |
// |          register, with sticky underflow flag. BYPASS masks busy     |
// |          while the last outstanding write is being retired.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_pend_ctr
  import regfile_scoreboard_pkg::*;
#(
  parameter int LEN_PEND = DEF_LEN_PEND,
  parameter bit BYPASS   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic pending,
  output logic full,
  output logic underflow
);

  localparam logic [LEN_PEND-1:0] PEND_MAX = LEN_PEND'(pend_max(LEN_PEND));
  localparam logic [LEN_PEND-1:0] PEND_ONE = LEN_PEND'(1);

  logic [LEN_PEND-1:0] count;

  // Count issues up and writebacks down; a writeback with nothing pending flags underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (dec && count == '0) begin
        underflow <= 1'b1;
      end
      if (inc && !dec && count != PEND_MAX) begin
        count <= count + PEND_ONE;
      end else if (dec && !inc && count != '0) begin
        count <= count - PEND_ONE;
      end
    end
  end

  assign pending = (count != '0);
  assign full    = (count == PEND_MAX);
  // With bypass, the retiring writeback's data is forwarded, so the register is free this cycle
  assign busy    = pending && !(BYPASS && dec && count == PEND_ONE);

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_scoreboard                                          |
// | Desc   : General-register file with per-register pending-write       |
// |          scoreboard. Supplies operands, stalls decode on RAW or a    |
// |          saturated destination, retires writebacks.                  |
// |          REGFILE_BYPASS_EN : forward writeback data to operand reads |
// |          when it retires the last outstanding write.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int LEN_REG   = DEF_LEN_REG,
  parameter int LEN_REGNO = DEF_LEN_REGNO,
  parameter int LEN_PEND  = DEF_LEN_PEND,
  parameter int R0_ZERO   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_REGNO-1:0] rd_regno_i,
  input  logic [LEN_REGNO-1:0] rs_regno_i,
  input  logic                 rd_src_i,
  input  logic                 rs_src_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_writes_i,
  input  logic                 issue_stall_i,
  output logic [LEN_REG-1:0]   rd_data_o,
  output logic [LEN_REG-1:0]   rs_data_o,
  output logic                 hazard_o,
  input  logic                 wb_valid_i,
  input  logic [LEN_REGNO-1:0] wb_regno_i,
  input  logic [LEN_REG-1:0]   wb_data_i,
  output logic                 reserved_o,
  output logic                 err_o
);

  localparam int NUM_REGS = 2 ** LEN_REGNO;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [LEN_REG-1:0]  regs [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] underflow;
  logic [NUM_REGS-1:0] byp_hit;
  logic                fire;
  logic                src_busy;
  logic                dst_full;

  assign src_busy = (rd_src_i && busy[rd_regno_i]) || (rs_src_i && busy[rs_regno_i]);
  assign dst_full = issue_writes_i && full[rd_regno_i];
  assign hazard_o = issue_valid_i && (src_busy || dst_full);
  assign fire     = issue_valid_i && !hazard_o && !issue_stall_i;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      // A hard-wired zero register is never reserved nor retired
      localparam bit IS_ZERO = (R0_ZERO != 0) && (i == 0);

      assign inc[i] = fire && issue_writes_i && (rd_regno_i == LEN_REGNO'(i)) && !IS_ZERO;
      assign dec[i] = wb_valid_i && (wb_regno_i == LEN_REGNO'(i)) && !IS_ZERO;

      regfile_pend_ctr #(
        .LEN_PEND (LEN_PEND),
        .BYPASS   (BYPASS)
      ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc[i]),
        .dec       (dec[i]),
        .busy      (busy[i]),
        .pending   (pending[i]),
        .full      (full[i]),
        .underflow (underflow[i])
      );

      // Busy masked while still pending only happens on a bypassed retirement
      assign byp_hit[i] = pending[i] && !busy[i];
    end
  endgenerate

  assign reserved_o = |pending;
  assign err_o      = |underflow;

  // Retire writeback data into the array; register 0 ignores writes when hard-wired
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wb_valid_i && !((R0_ZERO != 0) && wb_regno_i == '0)) begin
      regs[wb_regno_i] <= wb_data_i;
    end
  end

  // Operand muxes: array contents, forwarded writeback, or hard zero
  always_comb begin
    rd_data_o = regs[rd_regno_i];
    rs_data_o = regs[rs_regno_i];
    if (byp_hit[rd_regno_i]) rd_data_o = wb_data_i;
    if (byp_hit[rs_regno_i]) rs_data_o = wb_data_i;
    if ((R0_ZERO != 0) && rd_regno_i == '0) rd_data_o = '0;
    if ((R0_ZERO != 0) && rs_regno_i == '0) rs_data_o = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_regfile_scoreboard                                       |
// | Desc   : Self-checking bench for regfile_scoreboard: vector table,   |
// |          hand-written corner sequences, and a randomised phase with  |
// |          a writeback queue and a reference model.                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_regno, rs_regno, wb_regno;
  logic        rd_src, rs_src, issue_valid, issue_writes, issue_stall, wb_valid;
  logic [15:0] wb_data;
  logic [15:0] rd_data, rs_data, rd_data_z, rs_data_z;
  logic        hazard, reserved, err, hazard_z, reserved_z, err_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_regno_i(rd_regno), .rs_regno_i(rs_regno),
    .rd_src_i(rd_src), .rs_src_i(rs_src), .issue_valid_i(issue_valid),
    .issue_writes_i(issue_writes), .issue_stall_i(issue_stall),
    .rd_data_o(rd_data), .rs_data_o(rs_data), .hazard_o(hazard),
    .wb_valid_i(wb_valid), .wb_regno_i(wb_regno), .wb_data_i(wb_data),
    .reserved_o(reserved), .err_o(err)
  );

  regfile_scoreboard #(.R0_ZERO(1)) dut_z (
    .clk(clk), .rst(rst), .rd_regno_i(rd_regno), .rs_regno_i(rs_regno),
    .rd_src_i(rd_src), .rs_src_i(rs_src), .issue_valid_i(issue_valid),
    .issue_writes_i(issue_writes), .issue_stall_i(issue_stall),
    .rd_data_o(rd_data_z), .rs_data_o(rs_data_z), .hazard_o(hazard_z),
    .wb_valid_i(wb_valid), .wb_regno_i(wb_regno), .wb_data_i(wb_data),
    .reserved_o(reserved_z), .err_o(err_z)
  );

  typedef struct {
    logic wbv; logic [2:0] wbr; logic [15:0] wbd;
    logic iv, iw, st, rds, rss; logic [2:0] rd, rs;
    logic hz; logic [15:0] erd, ers; logic res, er;
  } vec_t;

  typedef struct { logic [2:0] r; logic [15:0] d; } wb_t;

  vec_t        vt [10];
  wb_t         q [$];
  int          pend_m [8];
  logic [15:0] arr_m [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, iw, st, rds, rss, input logic [2:0] rd, rs,
                       input logic wv, input logic [2:0] wr, input logic [15:0] wd);
    issue_valid = iv; issue_writes = iw; issue_stall = st; rd_src = rds; rs_src = rss;
    rd_regno = rd; rs_regno = rs; wb_valid = wv; wb_regno = wr; wb_data = wd;
  endtask

  task automatic idle_rd(input logic [2:0] rd);
    drive(0, 0, 0, 0, 0, rd, 3'd0, 0, 3'd0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_rd(3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // wbv wbr wbd | iv iw st rds rss | rd rs | hz erd ers | res err
    vt[0] = '{0, 3'd0, 16'h0,    1, 1, 0, 1, 1, 3'd1, 3'd2, 0, 16'h0, 16'h0, 1, 0};
    vt[1] = '{0, 3'd0, 16'h0,    1, 0, 0, 1, 1, 3'd2, 3'd1, 1, 16'h0, 16'h0, 1, 0};
    vt[2] = '{1, 3'd1, 16'h1111, 1, 0, 0, 1, 1, 3'd2, 3'd1, !BYP, 16'h0,
              (BYP ? 16'h1111 : 16'h0000), 0, 0};
    vt[3] = '{0, 3'd0, 16'h0,    1, 0, 0, 1, 1, 3'd1, 3'd2, 0, 16'h1111, 16'h0, 0, 0};
    vt[4] = '{0, 3'd0, 16'h0,    1, 1, 1, 0, 0, 3'd3, 3'd0, 0, 16'h0, 16'h0, 0, 0};
    vt[5] = '{0, 3'd0, 16'h0,    1, 1, 0, 0, 0, 3'd3, 3'd0, 0, 16'h0, 16'h0, 1, 0};
    vt[6] = '{0, 3'd0, 16'h0,    1, 1, 0, 0, 0, 3'd3, 3'd0, 0, 16'h0, 16'h0, 1, 0};
    vt[7] = '{1, 3'd3, 16'h3333, 0, 0, 0, 0, 0, 3'd3, 3'd1, 0, 16'h0, 16'h1111, 1, 0};
    vt[8] = '{1, 3'd3, 16'h4444, 1, 0, 0, 1, 0, 3'd3, 3'd1, !BYP,
              (BYP ? 16'h4444 : 16'h3333), 16'h1111, 0, 0};
    vt[9] = '{0, 3'd0, 16'h0,    0, 0, 0, 0, 0, 3'd3, 3'd1, 0, 16'h4444, 16'h1111, 0, 0};

    idle_rd(3'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset clears data, reservations and the error flag
    drive(1, 1, 0, 0, 0, 3'd5, 3'd0, 1, 3'd3, 16'h1234);
    tick();
    idle_rd(3'd3);
    #1;
    chk("pre_rst_r3", rd_data, 16'h1234);
    chk("pre_rst_res", reserved, 1'b1);
    chk("pre_rst_err", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 1, 3'd3, 3'd5, 0, 3'd0, 16'h0);
    #1;
    chk("rst_r3", rd_data, 16'h0000);
    chk("rst_res", reserved, 1'b0);
    chk("rst_hz", hazard, 1'b0);
    chk("rst_err", err, 1'b0);

    // Vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].iv, vt[i].iw, vt[i].st, vt[i].rds, vt[i].rss, vt[i].rd, vt[i].rs,
            vt[i].wbv, vt[i].wbr, vt[i].wbd);
      #1;
      chk($sformatf("vec%0d_hz", i), hazard, vt[i].hz);
      chk($sformatf("vec%0d_rd", i), rd_data, vt[i].erd);
      chk($sformatf("vec%0d_rs", i), rs_data, vt[i].ers);
      tick();
      chk($sformatf("vec%0d_res", i), reserved, vt[i].res);
      chk($sformatf("vec%0d_err", i), err, vt[i].er);
    end

    // RAW hazard with a queued writeback of 0x00AA
    do_reset();
    q.delete();
    drive(1, 1, 0, 0, 0, 3'd2, 3'd0, 0, 3'd0, 16'h0);
    #1;
    chk("raw_issue_hz", hazard, 1'b0);
    tick();
    q.push_back('{3'd2, 16'h00AA});
    drive(1, 0, 0, 0, 1, 3'd0, 3'd2, 0, 3'd0, 16'h0);
    #1;
    chk("raw_wait_hz", hazard, 1'b1);
    tick();
    begin
      wb_t e;
      e = q.pop_front();
      drive(1, 0, 0, 0, 1, 3'd0, 3'd2, 1, e.r, e.d);
    end
    #1;
    chk("raw_wb_hz", hazard, !BYP);
    if (BYP) chk("raw_wb_rs", rs_data, 16'h00AA);
    tick();
    drive(1, 0, 0, 0, 1, 3'd0, 3'd2, 0, 3'd0, 16'h0);
    #1;
    chk("raw_rel_hz", hazard, 1'b0);
    chk("raw_rel_rs", rs_data, 16'h00AA);

    // Randomised phase against a reference model and in-flight writeback queue
    do_reset();
    q.delete();
    for (int k = 0; k < 8; k++) begin pend_m[k] = 0; arr_m[k] = 16'h0; end
    for (int c = 0; c < 300; c++) begin
      logic iv, iw, st, rds, rss, wv, brd, brs, hz_e, fire_e, any;
      logic [2:0] rd, rs, wr;
      logic [15:0] wd, erd, ers;
      wb_t e;
      iv = ($urandom_range(0, 9) < 7); iw = $urandom_range(0, 1) == 1;
      st = ($urandom_range(0, 9) == 0); rds = $urandom_range(0, 1) == 1;
      rss = $urandom_range(0, 1) == 1;
      rd = 3'($urandom_range(0, 7)); rs = 3'($urandom_range(0, 7));
      wv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      wr = 3'd0; wd = 16'h0;
      if (wv) begin e = q.pop_front(); wr = e.r; wd = e.d; end
      brd = BYP && wv && wr == rd && pend_m[rd] == 1;
      brs = BYP && wv && wr == rs && pend_m[rs] == 1;
      hz_e = iv && ((rds && pend_m[rd] != 0 && !brd) || (rss && pend_m[rs] != 0 && !brs) ||
                    (iw && pend_m[rd] == 3));
      erd = brd ? wd : arr_m[rd];
      ers = brs ? wd : arr_m[rs];
      fire_e = iv && !hz_e && !st;
      drive(iv, iw, st, rds, rss, rd, rs, wv, wr, wd);
      #1;
      chk("rnd_hz", hazard, hz_e);
      chk("rnd_rd", rd_data, erd);
      chk("rnd_rs", rs_data, ers);
      tick();
      if (wv) begin arr_m[wr] = wd; pend_m[wr] = pend_m[wr] - 1; end
      if (fire_e && iw) begin
        pend_m[rd] = pend_m[rd] + 1;
        q.push_back('{rd, 16'($urandom)});
      end
      any = 1'b0;
      for (int k = 0; k < 8; k++) if (pend_m[k] != 0) any = 1'b1;
      chk("rnd_res", reserved, any);
      chk("rnd_err", err, 1'b0);
    end

    // Counter saturation on r5
    do_reset();
    q.delete();
    for (int n = 0; n < 3; n++) begin
      drive(1, 1, 0, 0, 0, 3'd5, 3'd0, 0, 3'd0, 16'h0);
      #1;
      chk($sformatf("sat_issue%0d_hz", n), hazard, 1'b0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 3'd5, 3'd0, 0, 3'd0, 16'h0);
    #1;
    chk("sat_full_hz", hazard, 1'b1);
    tick();
    drive(1, 1, 0, 0, 0, 3'd5, 3'd0, 1, 3'd5, 16'h0505);
    #1;
    chk("sat_wb_hz", hazard, 1'b1);
    tick();
    drive(1, 1, 0, 0, 0, 3'd5, 3'd0, 0, 3'd0, 16'h0);
    #1;
    chk("sat_fourth_hz", hazard, 1'b0);
    tick();
    #1;
    chk("sat_refull_hz", hazard, 1'b1);
    for (int n = 0; n < 2; n++) begin
      drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd5, 16'h0505);
      tick();
    end
    idle_rd(3'd0);
    #1;
    chk("sat_drain2_res", reserved, 1'b1);
    drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd5, 16'h0505);
    tick();
    idle_rd(3'd0);
    #1;
    chk("sat_drain3_res", reserved, 1'b0);
    chk("sat_drain_err", err, 1'b0);

    // Same-cycle increment and writeback on r1
    do_reset();
    drive(1, 1, 0, 0, 0, 3'd1, 3'd0, 0, 3'd0, 16'h0);
    tick();
    drive(1, 1, 0, 0, 0, 3'd1, 3'd0, 1, 3'd1, 16'h0101);
    #1;
    chk("same_hz", hazard, 1'b0);
    tick();
    idle_rd(3'd0);
    #1;
    chk("same_res", reserved, 1'b1);
    drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd1, 16'h0202);
    tick();
    idle_rd(3'd0);
    #1;
    chk("same_drain_res", reserved, 1'b0);
    chk("same_drain_err", err, 1'b0);

    // Underflow: data still written, sticky error
    do_reset();
    drive(0, 0, 0, 0, 0, 3'd4, 3'd0, 1, 3'd4, 16'hBEEF);
    tick();
    idle_rd(3'd4);
    #1;
    chk("unf_r4", rd_data, 16'hBEEF);
    chk("unf_err", err, 1'b1);
    repeat (3) tick();
    chk("unf_err_held", err, 1'b1);
    do_reset();
    chk("unf_err_rst", err, 1'b0);

    // Downstream stall blocks the reservation
    drive(1, 1, 1, 0, 0, 3'd6, 3'd0, 0, 3'd0, 16'h0);
    tick();
    idle_rd(3'd0);
    #1;
    chk("stall_res", reserved, 1'b0);

    // Hard-wired zero register versus ordinary register 0
    do_reset();
    drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 3'd0, 16'hFFFF);
    tick();
    idle_rd(3'd0);
    #1;
    chk("z_r0", rd_data_z, 16'h0000);
    chk("z_err", err_z, 1'b0);
    chk("nz_r0", rd_data, 16'hFFFF);
    chk("nz_err", err, 1'b1);
    drive(1, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 16'h0);
    tick();
    drive(1, 0, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 16'h0);
    #1;
    chk("z_hz", hazard_z, 1'b0);
    chk("z_res", reserved_z, 1'b0);
    chk("nz_hz", hazard, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
